// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined MIPS core: widths, reset values and
// the fetch-stage state encoding.
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_t;

    // Restart addresses may come from a raw register value, so force word alignment.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry holding register for an instruction that arrived while decode
// was stalled; drained back into IF/ID when the stall releases.
module if_skid_buffer
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [ADDR_W-1:0]  load_pc4,
    output logic [INSTR_W-1:0] skid_instr,
    output logic [ADDR_W-1:0]  skid_pc4
);

    // Clear wins so a redirect never leaves a stale wrong-path instruction behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_instr <= NOP_INSTR;
            skid_pc4   <= '0;
        end else if (clear) begin
            skid_instr <= NOP_INSTR;
            skid_pc4   <= '0;
        end else if (load) begin
            skid_instr <= load_instr;
            skid_pc4   <= load_pc4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the req/ack handshake to
// instruction memory and fills the IF/ID register, honouring stalls and redirects.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  target;
    logic [31:0]  pc_plus4;
    logic [31:0]  rd_pc;
    logic         accept;
    logic         skid_load;
    logic         skid_clear;
    logic [31:0]  skid_instr;
    logic [31:0]  skid_pc4;

    assign imem_req  = (state != ST_HOLD);
    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign rd_pc     = word_align(redirect_pc);

    always_comb begin
        accept     = !if_id_valid || !stall;
        skid_load  = (state == ST_FETCH) && imem_ack && !redirect && !accept;
        skid_clear = (state == ST_HOLD) && redirect;
    end

    if_skid_buffer u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (skid_load),
        .clear      (skid_clear),
        .load_instr (imem_rdata),
        .load_pc4   (pc_plus4),
        .skid_instr (skid_instr),
        .skid_pc4   (skid_pc4)
    );

    // A request in flight when a redirect lands must still be retired by its
    // ack; ST_DISCARD swallows that response and remembers the newest target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_FETCH;
            pc          <= RESET_PC;
            target      <= '0;
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
            if_id_pc4   <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (redirect) begin
                        if_id_valid <= 1'b0;
                        if (imem_ack) begin
                            pc <= rd_pc;
                        end else begin
                            target <= rd_pc;
                            state  <= ST_DISCARD;
                        end
                    end else if (imem_ack) begin
                        pc <= pc_plus4;
                        if (accept) begin
                            if_id_valid <= 1'b1;
                            if_id_instr <= imem_rdata;
                            if_id_pc4   <= pc_plus4;
                        end else begin
                            state <= ST_HOLD;
                        end
                    end else if (!stall) begin
                        if_id_valid <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (redirect) begin
                        pc          <= rd_pc;
                        if_id_valid <= 1'b0;
                        state       <= ST_FETCH;
                    end else if (!stall) begin
                        if_id_valid <= 1'b1;
                        if_id_instr <= skid_instr;
                        if_id_pc4   <= skid_pc4;
                        state       <= ST_FETCH;
                    end
                end
                ST_DISCARD: begin
                    if_id_valid <= 1'b0;
                    if (imem_ack) begin
                        pc    <= redirect ? rd_pc : target;
                        state <= ST_FETCH;
                    end else if (redirect) begin
                        target <= rd_pc;
                    end
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations, then randomized latency/stall/redirect against a fetch-stream model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;

    int errors = 0;
    int checks = 0;

    // Memory responder state
    int  wait_cnt = 0;
    int  cur_lat = 0;
    int  fixed_lat = 0;
    bit  rand_lat = 1'b0;

    // Behavioural model: next fetch address, decoded-side register, held
    // instructions waiting for decode, and a pending wrong-path response.
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic [63:0] m_hold_q[$];
    bit          m_discard;
    logic [31:0] m_target;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_id_valid (if_id_valid),
        .if_id_instr (if_id_instr),
        .if_id_pc4   (if_id_pc4)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] addr);
        return addr >> 2;
    endfunction

    function automatic bit m_req();
        return (m_hold_q.size() == 0);
    endfunction

    function automatic int pick_lat();
        return rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_pc      = 32'h0;
        m_valid   = 1'b0;
        m_instr   = 32'h0;
        m_pc4     = 32'h0;
        m_hold_q.delete();
        m_discard = 1'b0;
        m_target  = 32'h0;
    endtask

    // One clock of the fetch-stream rules, using the inputs presented this cycle.
    task automatic modelStep(input bit s, input bit r, input logic [31:0] rpc, input bit ack);
        logic [31:0] rd;
        logic [63:0] ent;
        rd = {rpc[31:2], 2'b00};
        if (m_hold_q.size() != 0) begin
            if (r) begin
                m_hold_q.delete();
                m_pc    = rd;
                m_valid = 1'b0;
            end else if (!s) begin
                ent     = m_hold_q.pop_front();
                m_instr = ent[63:32];
                m_pc4   = ent[31:0];
                m_valid = 1'b1;
            end
        end else if (m_discard) begin
            m_valid = 1'b0;
            if (ack) begin
                m_pc      = r ? rd : m_target;
                m_discard = 1'b0;
            end else if (r) begin
                m_target = rd;
            end
        end else if (r) begin
            m_valid = 1'b0;
            if (ack) begin
                m_pc = rd;
            end else begin
                m_discard = 1'b1;
                m_target  = rd;
            end
        end else if (ack) begin
            if (!m_valid || !s) begin
                m_instr = instr_of(m_pc);
                m_pc4   = m_pc + 32'd4;
                m_valid = 1'b1;
            end else begin
                m_hold_q.push_back({instr_of(m_pc), m_pc + 32'd4});
            end
            m_pc = m_pc + 32'd4;
        end else if (!s) begin
            m_valid = 1'b0;
        end
    endtask

    // Drive one cycle of inputs, let the memory answer, advance the model.
    task automatic applyStimulus(input bit s, input bit r, input logic [31:0] rpc);
        bit req_drv;
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        req_drv     = rst_n && m_req();
        imem_ack    = req_drv && (wait_cnt == cur_lat);
        imem_rdata  = imem_ack ? instr_of(imem_addr) : $urandom;
        @(posedge clk);
        if (rst_n) begin
            modelStep(s, r, rpc, imem_ack);
            if (req_drv) begin
                if (imem_ack) begin
                    wait_cnt = 0;
                    cur_lat  = pick_lat();
                end else begin
                    wait_cnt++;
                end
            end
        end
        #1;
    endtask

    task automatic doReset();
        rst_n    = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        imem_ack = 1'b0;
        modelReset();
        @(posedge clk);
        @(posedge clk);
        #1;
        wait_cnt = 0;
        cur_lat  = pick_lat();
        checkOutput("rst_valid", {31'b0, if_id_valid}, 32'h0);
        checkOutput("rst_instr", if_id_instr, 32'h0);
        checkOutput("rst_pc4",   if_id_pc4,   32'h0);
        checkOutput("rst_req",   {31'b0, imem_req}, 32'h1);
        checkOutput("rst_addr",  imem_addr,   32'h0);
        rst_n = 1'b1;
    endtask

    // Continuous comparison against the model on every out-of-reset cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                checkOutput("cmp_req", {31'b0, imem_req}, {31'b0, m_req()});
                if (m_req())
                    checkOutput("cmp_addr", imem_addr, m_pc);
                checkOutput("cmp_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
                checkOutput("cmp_instr", if_id_instr, m_instr);
                checkOutput("cmp_pc4",   if_id_pc4,   m_pc4);
            end
        end
    end

    initial begin
        $display("[TB] fetch_stage bench start");

        // Zero-wait memory streams one instruction per cycle
        fixed_lat = 0;
        doReset();
        applyStimulus(0, 0, 0);
        checkOutput("zw0_valid", {31'b0, if_id_valid}, 32'h1);
        checkOutput("zw0_instr", if_id_instr, 32'd0);
        checkOutput("zw0_pc4",   if_id_pc4,   32'd4);
        applyStimulus(0, 0, 0);
        checkOutput("zw1_instr", if_id_instr, 32'd1);
        checkOutput("zw1_pc4",   if_id_pc4,   32'd8);
        applyStimulus(0, 0, 0);
        checkOutput("zw2_instr", if_id_instr, 32'd2);
        checkOutput("zw2_pc4",   if_id_pc4,   32'd12);

        // Three-cycle ack latency
        fixed_lat = 2;
        doReset();
        applyStimulus(0, 0, 0);
        checkOutput("lat_c1_addr",  imem_addr, 32'h0);
        checkOutput("lat_c1_valid", {31'b0, if_id_valid}, 32'h0);
        applyStimulus(0, 0, 0);
        checkOutput("lat_c2_req",   {31'b0, imem_req}, 32'h1);
        checkOutput("lat_c2_addr",  imem_addr, 32'h0);
        applyStimulus(0, 0, 0);
        checkOutput("lat_ack_valid", {31'b0, if_id_valid}, 32'h1);
        checkOutput("lat_ack_pc4",   if_id_pc4, 32'd4);
        checkOutput("lat_next_addr", imem_addr, 32'd4);

        // Stall into the skid and release
        fixed_lat = 0;
        doReset();
        applyStimulus(0, 0, 0);
        applyStimulus(1, 0, 0);
        checkOutput("hold_req",   {31'b0, imem_req}, 32'h0);
        checkOutput("hold_instr", if_id_instr, 32'd0);
        applyStimulus(1, 0, 0);
        checkOutput("hold2_req",  {31'b0, imem_req}, 32'h0);
        applyStimulus(0, 0, 0);
        checkOutput("rel_valid", {31'b0, if_id_valid}, 32'h1);
        checkOutput("rel_instr", if_id_instr, 32'd1);
        checkOutput("rel_pc4",   if_id_pc4,   32'd8);
        checkOutput("rel_addr",  imem_addr,   32'd8);
        applyStimulus(0, 0, 0);
        checkOutput("resume_instr", if_id_instr, 32'd2);

        // Redirect while a request is outstanding
        fixed_lat = 2;
        doReset();
        applyStimulus(0, 0, 0);
        applyStimulus(0, 1, 32'h0000_0100);
        checkOutput("disc_valid", {31'b0, if_id_valid}, 32'h0);
        checkOutput("disc_addr",  imem_addr, 32'h0);
        applyStimulus(0, 0, 0);
        checkOutput("redir_valid", {31'b0, if_id_valid}, 32'h0);
        checkOutput("redir_addr",  imem_addr, 32'h0000_0100);

        // Redirect coincident with ack and stall, unaligned target
        fixed_lat = 0;
        doReset();
        applyStimulus(0, 0, 0);
        applyStimulus(1, 1, 32'h0000_0203);
        checkOutput("coin_addr",  imem_addr, 32'h0000_0200);
        checkOutput("coin_valid", {31'b0, if_id_valid}, 32'h0);

        // PC wrap, then reset in the middle of a wait
        doReset();
        applyStimulus(0, 1, 32'hFFFF_FFFC);
        checkOutput("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        fixed_lat = 2;
        applyStimulus(0, 0, 0);
        checkOutput("wrap_pc4",   if_id_pc4,   32'h0);
        checkOutput("wrap_instr", if_id_instr, 32'h3FFF_FFFF);
        checkOutput("wrap_addr",  imem_addr,   32'h0);
        applyStimulus(0, 0, 0);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("midrst_valid", {31'b0, if_id_valid}, 32'h0);
        checkOutput("midrst_addr",  imem_addr, 32'h0);
        checkOutput("midrst_req",   {31'b0, imem_req}, 32'h1);

        // Randomized traffic against the model
        rand_lat = 1'b1;
        doReset();
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            applyStimulus($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 10, rpc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
